i2c_apb_arbiter: RTL and testbench

- Shares the single CoreI2C APB slave port between two requesters, e.g. the ADS1115 configuration FSM (m0) and the conversion-readback FSM (m1).
- A requester owns the bus for a whole I2C transaction (START to STOP) by holding a lock, so the two requesters' CoreI2C register accesses never interleave.
- Ties on simultaneous requests are resolved round-robin.
- A hold-timeout recovers the bus from a requester that stalls without releasing it.

---
 rtl/i2c_apb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_i2c_apb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_apb_arbiter.sv
// Two-requester lock-based arbiter in front of the single CoreI2C APB slave port.
// Ownership spans a full I2C transaction; ties alternate; a stalled owner is evicted.
module i2c_apb_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_lock,
    output logic              m0_gnt,
    input  logic              m0_psel,
    input  logic              m0_penable,
    input  logic              m0_pwrite,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic [DATA_W-1:0] m0_pwdata,
    output logic [DATA_W-1:0] m0_prdata,
    output logic              m0_pready,
    input  logic              m1_lock,
    output logic              m1_gnt,
    input  logic              m1_psel,
    input  logic              m1_penable,
    input  logic              m1_pwrite,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic [DATA_W-1:0] m1_pwdata,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              m1_pready,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    output logic              owner,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_e;

    state_e             state_q, state_d;
    logic               last_owner_q, last_owner_d;
    logic               owner_q, owner_d;
    logic               timeout_err_q, timeout_err_d;
    logic [1:0]         armed_q, armed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0]         lock_s, elig_s;
    logic               pick_s, active_s, done_s;
    logic               own_lock_s, own_psel_s, own_penable_s, own_pwrite_s;
    logic [ADDR_W-1:0]  own_paddr_s;
    logic [DATA_W-1:0]  own_pwdata_s;

    // Select the current owner's request signals and derive arbitration terms
    always_comb begin
        lock_s        = {m1_lock, m0_lock};
        elig_s        = lock_s & armed_q;
        pick_s        = (elig_s == 2'b11) ? ~last_owner_q : elig_s[1];
        active_s      = (state_q != IDLE);
        own_lock_s    = last_owner_q ? m1_lock    : m0_lock;
        own_psel_s    = last_owner_q ? m1_psel    : m0_psel;
        own_penable_s = last_owner_q ? m1_penable : m0_penable;
        own_pwrite_s  = last_owner_q ? m1_pwrite  : m0_pwrite;
        own_paddr_s   = last_owner_q ? m1_paddr   : m0_paddr;
        own_pwdata_s  = last_owner_q ? m1_pwdata  : m0_pwdata;
        done_s        = own_psel_s & own_penable_s & pready;
    end

    // Next-state: arbitration, release, drain and hold-timeout
    always_comb begin
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        armed_d       = armed_q | ~lock_s;
        case (state_q)
            IDLE: begin
                if (|elig_s) begin
                    state_d      = pick_s ? OWN1 : OWN0;
                    last_owner_d = pick_s;
                    owner_d      = pick_s;
                    cnt_d        = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0, OWN1: begin
                // Lock release takes priority over an expiring timeout
                if (!own_lock_s) begin
                    if (own_psel_s && !done_s) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (own_psel_s) begin
                    cnt_d = {CNT_W{1'b0}};
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d                = IDLE;
                    timeout_err_d          = 1'b1;
                    armed_d[last_owner_q]  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (done_s || !own_psel_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_owner_q  <= 1'b1;
            owner_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            armed_q       <= 2'b11;
            cnt_q         <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            last_owner_q  <= last_owner_d;
            owner_q       <= owner_d;
            timeout_err_q <= timeout_err_d;
            armed_q       <= armed_d;
            cnt_q         <= cnt_d;
        end
    end

    // Grants and APB muxing; the non-owner never reaches the slave
    always_comb begin
        m0_gnt      = active_s & ~last_owner_q;
        m1_gnt      = active_s & last_owner_q;
        busy        = active_s;
        owner       = owner_q;
        timeout_err = timeout_err_q;
        if (active_s) begin
            psel    = own_psel_s;
            penable = own_penable_s;
            pwrite  = own_pwrite_s;
            paddr   = own_paddr_s;
            pwdata  = own_pwdata_s;
        end else begin
            psel    = 1'b0;
            penable = 1'b0;
            pwrite  = 1'b0;
            paddr   = {ADDR_W{1'b0}};
            pwdata  = {DATA_W{1'b0}};
        end
        if (m0_gnt) begin
            m0_prdata = prdata;
            m0_pready = pready;
        end else begin
            m0_prdata = {DATA_W{1'b0}};
            m0_pready = 1'b0;
        end
        if (m1_gnt) begin
            m1_prdata = prdata;
            m1_pready = pready;
        end else begin
            m1_prdata = {DATA_W{1'b0}};
            m1_pready = 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// Directed-plus-random bench for i2c_apb_arbiter with a short hold timeout.
module tb_i2c_apb_arbiter;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m0_lock = 1'b0, m0_psel = 1'b0, m0_penable = 1'b0, m0_pwrite = 1'b0;
    logic m1_lock = 1'b0, m1_psel = 1'b0, m1_penable = 1'b0, m1_pwrite = 1'b0;
    logic [AW-1:0] m0_paddr = '0, m1_paddr = '0;
    logic [DW-1:0] m0_pwdata = '0, m1_pwdata = '0;
    logic [DW-1:0] prdata = '0;
    logic pready = 1'b0;
    logic m0_gnt, m1_gnt, m0_pready, m1_pready;
    logic [DW-1:0] m0_prdata, m1_prdata;
    logic psel, penable, pwrite, owner, busy, timeout_err;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;

    int passed = 0;
    int total = 0;
    logic exp_last = 1'b1;   // reference: most recent owner, drives the tie rule

    i2c_apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_psel(m0_psel), .m0_penable(m0_penable),
        .m0_pwrite(m0_pwrite), .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata),
        .m0_prdata(m0_prdata), .m0_pready(m0_pready),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_psel(m1_psel), .m1_penable(m1_penable),
        .m1_pwrite(m1_pwrite), .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata),
        .m1_prdata(m1_prdata), .m1_pready(m1_pready),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int m, input logic s, input logic en, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (m == 0) begin
            m0_psel = s; m0_penable = en; m0_pwrite = wr; m0_paddr = a; m0_pwdata = d;
        end else begin
            m1_psel = s; m1_penable = en; m1_pwrite = wr; m1_paddr = a; m1_pwdata = d;
        end
    endtask

    // One APB transfer by owner m; slave must see exactly what m requested
    task automatic xfer(input int m, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] rd, input int waits);
        drive_m(m, 1'b1, 1'b0, wr, a, d);
        #1;
        chk("setup_psel", psel, 1'b1);
        chk("setup_penable", penable, 1'b0);
        chk("setup_pwrite", pwrite, wr);
        chk("setup_paddr", paddr, a);
        if (wr) chk("setup_pwdata", pwdata, d);
        step();
        drive_m(m, 1'b1, 1'b1, wr, a, d);
        pready = 1'b0;
        for (int w = 0; w < waits; w++) begin
            #1;
            chk("wait_pready", (m == 0) ? m0_pready : m1_pready, 1'b0);
            step();
        end
        pready = 1'b1;
        prdata = rd;
        #1;
        chk("access_pready", (m == 0) ? m0_pready : m1_pready, 1'b1);
        chk("nonowner_pready", (m == 0) ? m1_pready : m0_pready, 1'b0);
        chk("nonowner_prdata", (m == 0) ? m1_prdata : m0_prdata, '0);
        if (!wr) chk("read_data", (m == 0) ? m0_prdata : m1_prdata, rd);
        step();
        drive_m(m, 1'b0, 1'b0, 1'b0, '0, '0);
        pready = 1'b0;
        prdata = '0;
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rdw;
        logic win;

        // Reset state
        #3;
        chk("rst_m0_gnt", m0_gnt, 1'b0);
        chk("rst_m1_gnt", m1_gnt, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_psel", psel, 1'b0);
        chk("rst_terr", timeout_err, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // Single requester grant latency and transfers
        m0_lock = 1'b1;
        #1;
        chk("m0_gnt_latency", m0_gnt, 1'b0);
        step();
        exp_last = 1'b0;
        chk("m0_gnt", m0_gnt, 1'b1);
        chk("owner_m0", owner, 1'b0);
        chk("busy_own", busy, 1'b1);
        xfer(0, 1'b1, 9'h000, 8'hE0, 8'h00, 0);
        xfer(0, 1'b0, 9'h004, 8'h00, 8'h08, 1);
        for (int i = 0; i < 4; i++) begin
            ra = AW'($urandom);
            rdw = DW'($urandom);
            xfer(0, 1'($urandom), ra, DW'($urandom), rdw, int'($urandom_range(2, 0)));
        end
        m0_lock = 1'b0;
        step();
        chk("rel_busy", busy, 1'b0);
        chk("rel_m0_gnt", m0_gnt, 1'b0);

        // Tie after reset, release, exactly one idle cycle before handoff
        rst_n = 1'b0;
        exp_last = 1'b1;
        step();
        m0_lock = 1'b1;
        m1_lock = 1'b1;
        rst_n = 1'b1;
        step();
        win = ~exp_last;
        exp_last = win;
        chk("tie_m0_gnt", m0_gnt, !win);
        chk("tie_m1_gnt", m1_gnt, win);
        m0_lock = 1'b0;
        step();
        chk("gap_busy", busy, 1'b0);
        chk("gap_m1_gnt", m1_gnt, 1'b0);
        step();
        exp_last = 1'b1;
        chk("hand_m1_gnt", m1_gnt, 1'b1);
        chk("hand_owner", owner, 1'b1);

        // Non-owner psel is blocked while m1 owns the bus
        drive_m(0, 1'b1, 1'b1, 1'b1, 9'h1A5, 8'h5A);
        #1;
        chk("blocked_psel", psel, 1'b0);
        chk("blocked_pwrite", pwrite, 1'b0);
        xfer(1, 1'b1, AW'($urandom), DW'($urandom), 8'h00, 0);
        xfer(1, 1'b0, AW'($urandom), 8'h00, DW'($urandom), 2);
        drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0);

        // Lock dropped during setup: drain until the slow completion
        drive_m(1, 1'b1, 1'b0, 1'b1, 9'h008, 8'h90);
        m1_lock = 1'b0;
        step();
        chk("drain_gnt", m1_gnt, 1'b1);
        drive_m(1, 1'b1, 1'b1, 1'b1, 9'h008, 8'h90);
        for (int w = 0; w < 3; w++) begin
            #1;
            chk("drain_psel", psel, 1'b1);
            chk("drain_paddr", paddr, 9'h008);
            chk("drain_pwdata", pwdata, 8'h90);
            step();
        end
        pready = 1'b1;
        #1;
        chk("drain_done", m1_pready, 1'b1);
        step();
        drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
        pready = 1'b0;
        chk("drain_idle", busy, 1'b0);
        chk("drain_gnt_off", m1_gnt, 1'b0);

        // Hold timeout: m0 stalls, m1 waits pending
        m0_lock = 1'b1;
        step();
        chk("tmo_grant", m0_gnt, 1'b1);
        for (int k = 1; k < TMO; k++) begin
            if (k == 5) m1_lock = 1'b1;
            step();
            chk("tmo_held", m0_gnt, 1'b1);
            chk("tmo_no_err", timeout_err, 1'b0);
        end
        step();
        chk("tmo_release", m0_gnt, 1'b0);
        chk("tmo_err", timeout_err, 1'b1);
        chk("tmo_busy", busy, 1'b0);
        step();
        chk("tmo_m1_gnt", m1_gnt, 1'b1);
        chk("tmo_err_once", timeout_err, 1'b0);
        chk("tmo_owner", owner, 1'b1);
        m1_lock = 1'b0;
        step();
        step();
        chk("disarmed_0", m0_gnt, 1'b0);
        step();
        chk("disarmed_1", m0_gnt, 1'b0);
        m0_lock = 1'b0;
        step();
        m0_lock = 1'b1;
        step();
        chk("rearmed", m0_gnt, 1'b1);

        // Asynchronous reset during an access phase
        drive_m(0, 1'b1, 1'b0, 1'b1, AW'($urandom), DW'($urandom));
        step();
        m0_penable = 1'b1;
        #1;
        chk("pre_rst_psel", psel, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_psel", psel, 1'b0);
        chk("arst_penable", penable, 1'b0);
        chk("arst_m0_gnt", m0_gnt, 1'b0);
        chk("arst_busy", busy, 1'b0);
        drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        m1_lock = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_m0_gnt", m0_gnt, 1'b1);
        chk("post_rst_m1_gnt", m1_gnt, 1'b0);
        chk("post_rst_owner", owner, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
